// File: rtl/ramspx_clr.sv
// Single-port RAM with a hardware clear sequencer, per-bit write mask, selectable
// read-during-write and optional output register. Define RAMSPX_PAR_EN to add per-word parity.
module ramspx_clr #(
  parameter int               ADDRBIT = 11,
  parameter int               DEPTH   = 1536,
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] INITVAL = {WIDTH{1'b0}},
  parameter int               RDMODE  = 0,
  parameter int               OREG    = 0
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [ADDRBIT-1:0] a,
  input  logic               we,
  input  logic [WIDTH-1:0]   wm,
  input  logic [WIDTH-1:0]   di,
  input  logic               clr,
  input  logic               pinj,
  output logic [WIDTH-1:0]   dout,
  output logic               vld,
  output logic               busy,
  output logic               err,
  output logic               perr
);

  typedef enum logic {ST_CLR = 1'b0, ST_IDLE = 1'b1} state_t;

  localparam logic [ADDRBIT:0]   DEPTH_X  = (ADDRBIT+1)'(DEPTH);
  localparam logic [ADDRBIT-1:0] CNT_LAST = ADDRBIT'(DEPTH - 1);

  function automatic logic par_f(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  state_t               state_r;
  logic [ADDRBIT-1:0]   cnt_r;
  logic                 busy_r;
  logic [WIDTH-1:0]     mem_r [DEPTH];

  logic                 inrng_s, acc_s, oor_s;
  logic [ADDRBIT-1:0]   idx_s;
  logic [WIDTH-1:0]     rdw_s, mrg_s;
  logic                 pe0_s;
  logic                 s0_upd_s, s0_vld_s, s0_pe_s;
  logic [WIDTH-1:0]     s0_d_s;
  logic                 s1_upd_r, s1_vld_r, s1_pe_r;
  logic [WIDTH-1:0]     s1_d_r;
  logic                 o_upd_s, o_vld_s, o_pe_s;
  logic [WIDTH-1:0]     o_d_s;
  logic [WIDTH-1:0]     dout_r;
  logic                 vld_r, err_r, perr_r;

  // Address decode and masked merge of the addressed word
  always_comb begin
    inrng_s = ({1'b0, a} < DEPTH_X);
    acc_s   = ~busy_r & inrng_s;
    oor_s   = ~busy_r & ~inrng_s;
    if (inrng_s) begin
      idx_s = a;
    end else begin
      idx_s = {ADDRBIT{1'b0}};
    end
    rdw_s = mem_r[idx_s];
    mrg_s = (rdw_s & ~wm) | (di & wm);
  end

`ifdef RAMSPX_PAR_EN
  logic par_r [DEPTH];

  // Parity array shares the data array's write port timing
  always_ff @(posedge clk) begin
    if (state_r == ST_CLR) begin
      par_r[cnt_r] <= par_f(INITVAL);
    end else if (acc_s && we) begin
      par_r[idx_s] <= par_f(mrg_s) ^ pinj;
    end
  end

  assign pe0_s = (par_f(rdw_s) != par_r[idx_s]);
`else
  assign pe0_s = 1'b0 & pinj;
`endif

  // Clear sequencer: walks every word once after reset or an accepted clr
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_r <= ST_CLR;
      cnt_r   <= {ADDRBIT{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_CLR: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_IDLE;
            cnt_r   <= {ADDRBIT{1'b0}};
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + {{(ADDRBIT-1){1'b0}}, 1'b1};
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state_r <= ST_CLR;
            cnt_r   <= {ADDRBIT{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_CLR;
          cnt_r   <= {ADDRBIT{1'b0}};
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  // Data array write port; the array itself is initialised by the sequencer, not by reset
  always_ff @(posedge clk) begin
    if (state_r == ST_CLR) begin
      mem_r[cnt_r] <= INITVAL;
    end else if (acc_s && we) begin
      mem_r[idx_s] <= mrg_s;
    end
  end

  // First read stage; writes only update do in write-through mode
  always_comb begin
    s0_upd_s = acc_s & (~we | (RDMODE == 1));
    s0_vld_s = acc_s & ~we;
    s0_pe_s  = acc_s & ~we & pe0_s;
    if (we) begin
      s0_d_s = mrg_s;
    end else begin
      s0_d_s = rdw_s;
    end
  end

  // Optional pipeline stage; it keeps running through a clear so in-flight reads complete
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      s1_upd_r <= 1'b0;
      s1_vld_r <= 1'b0;
      s1_pe_r  <= 1'b0;
      s1_d_r   <= {WIDTH{1'b0}};
    end else begin
      s1_upd_r <= s0_upd_s;
      s1_vld_r <= s0_vld_s;
      s1_pe_r  <= s0_pe_s;
      s1_d_r   <= s0_d_s;
    end
  end

  // Select the stage that feeds the output register
  always_comb begin
    if (OREG != 0) begin
      o_upd_s = s1_upd_r;
      o_vld_s = s1_vld_r;
      o_pe_s  = s1_pe_r;
      o_d_s   = s1_d_r;
    end else begin
      o_upd_s = s0_upd_s;
      o_vld_s = s0_vld_s;
      o_pe_s  = s0_pe_s;
      o_d_s   = s0_d_s;
    end
  end

  // Output register; do holds between updates, err always one cycle after the access
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      dout_r <= {WIDTH{1'b0}};
      vld_r  <= 1'b0;
      err_r  <= 1'b0;
      perr_r <= 1'b0;
    end else begin
      if (o_upd_s) begin
        dout_r <= o_d_s;
      end
      vld_r  <= o_vld_s;
      perr_r <= o_pe_s;
      err_r  <= oor_s;
    end
  end

  assign dout = dout_r;
  assign vld  = vld_r;
  assign err  = err_r;
  assign perr = perr_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_ramspx_clr.sv
// Directed bench for ramspx_clr: instance A (RDMODE=0, OREG=0) and instance B
// (RDMODE=1, OREG=1) share stimulus and are checked against hand-computed tables.
module tb_ramspx_clr;

  localparam logic [31:0] INIT = 32'h5A5A_0F0F;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_;
  logic [10:0] a;
  logic        we, clr, pinj;
  logic [31:0] wm, di;
  logic [31:0] do_a, do_b;
  logic        vld_a, vld_b, busy_a, busy_b, err_a, err_b, perr_a, perr_b;

  always #5 clk = ~clk;

  ramspx_clr #(.INITVAL(INIT)) u_a (
    .clk(clk), .rst_(rst_), .a(a), .we(we), .wm(wm), .di(di), .clr(clr), .pinj(pinj),
    .dout(do_a), .vld(vld_a), .busy(busy_a), .err(err_a), .perr(perr_a)
  );

  ramspx_clr #(.INITVAL(INIT), .RDMODE(1), .OREG(1)) u_b (
    .clk(clk), .rst_(rst_), .a(a), .we(we), .wm(wm), .di(di), .clr(clr), .pinj(pinj),
    .dout(do_b), .vld(vld_b), .busy(busy_b), .err(err_b), .perr(perr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [10:0] a;
    logic [31:0] wm, di;
    logic [31:0] ado;
    logic        avld, aerr;
    logic [31:0] bdo;
    logic        bvld, berr;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [10:0] ad, input logic [31:0] m,
                              input logic [31:0] d, input logic [31:0] ado, input logic av,
                              input logic ae, input logic [31:0] bdo, input logic bv,
                              input logic be);
    vec_t v;
    v.we = w; v.a = ad; v.wm = m; v.di = d;
    v.ado = ado; v.avld = av; v.aerr = ae;
    v.bdo = bdo; v.bvld = bv; v.berr = be;
    return v;
  endfunction

  vec_t tbl [20];

  task automatic count_clear(output int n, output int pulses, input bit clr_at5);
    n = 0;
    pulses = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      clr = clr_at5 && (n == 5);
      if (vld_a || vld_b || err_a || err_b) pulses++;
    end while (busy_a && n < 4000);
    clr = 1'b0;
  endtask

  initial begin
    int n, pulses;
    logic [10:0] rb [6];

    tbl[0]  = mk(1'b0, 11'h5FF, 32'h0,       32'h0,       INIT,         1'b1, 1'b0, 32'h0,        1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 11'h010, ONES,        32'h12345678, INIT,        1'b0, 1'b0, INIT,         1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 11'h010, 32'h0000FFFF, ONES,       INIT,         1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 11'h010, 32'h0,       32'h0,       32'h1234FFFF, 1'b1, 1'b0, 32'h1234FFFF, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 11'h5FF, 32'h0,       32'h0,       INIT,         1'b1, 1'b0, 32'h1234FFFF, 1'b1, 1'b0);
    tbl[5]  = mk(1'b1, 11'h003, ONES,        32'hA5A5A5A5, INIT,        1'b0, 1'b0, INIT,         1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 11'h003, 32'h0,       32'h0,       32'hA5A5A5A5, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 11'h000, 32'h0,       32'h0,       INIT,         1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0);
    tbl[8]  = mk(1'b1, 11'h600, ONES,        32'h0,       INIT,         1'b0, 1'b1, INIT,         1'b1, 1'b1);
    tbl[9]  = mk(1'b0, 11'h7FF, 32'h0,       32'h0,       INIT,         1'b0, 1'b1, INIT,         1'b0, 1'b1);
    tbl[10] = mk(1'b0, 11'h000, 32'h0,       32'h0,       INIT,         1'b1, 1'b0, INIT,         1'b0, 1'b0);
    tbl[11] = mk(1'b1, 11'h000, 32'hFF000000, 32'h11223344, INIT,       1'b0, 1'b0, INIT,         1'b1, 1'b0);
    tbl[12] = mk(1'b0, 11'h000, 32'h0,       32'h0,       32'h115A0F0F, 1'b1, 1'b0, 32'h115A0F0F, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 11'h5FF, 32'h0,       32'h0,       INIT,         1'b1, 1'b0, 32'h115A0F0F, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 11'h003, 32'h0,       32'h0,       32'hA5A5A5A5, 1'b1, 1'b0, INIT,         1'b1, 1'b0);
    tbl[15] = mk(1'b1, 11'h5FF, 32'h0,       ONES,        32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 11'h5FF, 32'h0,       32'h0,       INIT,         1'b1, 1'b0, INIT,         1'b0, 1'b0);
    tbl[17] = mk(1'b0, 11'h5FF, 32'h0,       32'h0,       INIT,         1'b1, 1'b0, INIT,         1'b1, 1'b0);
    tbl[18] = mk(1'b1, 11'h5FE, ONES,        32'h0BADF00D, INIT,        1'b0, 1'b0, INIT,         1'b1, 1'b0);
    tbl[19] = mk(1'b0, 11'h5FE, 32'h0,       32'h0,       32'h0BADF00D, 1'b1, 1'b0, 32'h0BADF00D, 1'b0, 1'b0);

    // Reset state; accesses driven during the clear must be ignored
    rst_ = 1'b0; a = 11'h600; we = 1'b1; wm = ONES; di = 32'h0; clr = 1'b0; pinj = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy_a", {31'b0, busy_a}, 32'd1);
    chk("rst busy_b", {31'b0, busy_b}, 32'd1);
    chk("rst do_a", do_a, 32'h0);
    chk("rst vld/err/perr", {28'b0, vld_a, err_a, perr_a, vld_b | err_b | perr_b}, 32'h0);
    rst_ = 1'b1;
    count_clear(n, pulses, 1'b0);
    chk("clear length", n, 32'd1536);
    chk("pulses during clear", pulses, 32'd0);
    chk("busy_b after clear", {31'b0, busy_b}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      we = tbl[i].we; a = tbl[i].a; wm = tbl[i].wm; di = tbl[i].di;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d do_a", i), do_a, tbl[i].ado);
      chk($sformatf("v%0d vld_a", i), {31'b0, vld_a}, {31'b0, tbl[i].avld});
      chk($sformatf("v%0d err_a", i), {31'b0, err_a}, {31'b0, tbl[i].aerr});
      chk($sformatf("v%0d do_b", i), do_b, tbl[i].bdo);
      chk($sformatf("v%0d vld_b", i), {31'b0, vld_b}, {31'b0, tbl[i].bvld});
      chk($sformatf("v%0d err_b", i), {31'b0, err_b}, {31'b0, tbl[i].berr});
      chk($sformatf("v%0d perr", i), {30'b0, perr_a, perr_b}, 32'h0);
      chk($sformatf("v%0d busy", i), {30'b0, busy_a, busy_b}, 32'h0);
    end

    // clr together with a read: A delivers it, B's pipeline still drains it
    a = 11'h010; we = 1'b0; clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0; a = 11'h5FF;
    chk("clr busy", {31'b0, busy_a}, 32'd1);
    chk("clr inflight do_a", do_a, 32'h1234FFFF);
    chk("clr inflight vld_a", {31'b0, vld_a}, 32'd1);
    @(posedge clk);
    #1;
    chk("clr inflight do_b", do_b, 32'h1234FFFF);
    chk("clr inflight vld_b", {31'b0, vld_b}, 32'd1);
    chk("clr ignored read", {31'b0, vld_a}, 32'd0);

    // Reset at clear cycle 700, then a clr at cycle 5 of the restarted clear is ignored
    repeat (698) @(posedge clk);
    #1;
    rst_ = 1'b0;
    #1;
    chk("midclr rst busy", {30'b0, busy_a, busy_b}, 32'h3);
    chk("midclr rst do_a", do_a, 32'h0);
    chk("midclr rst do_b", do_b, 32'h0);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    count_clear(n, pulses, 1'b1);
    chk("restart clear length", n, 32'd1536);
    chk("restart pulses", pulses, 32'd0);

    rb[0] = 11'h000; rb[1] = 11'h003; rb[2] = 11'h010;
    rb[3] = 11'h2BC; rb[4] = 11'h5FE; rb[5] = 11'h5FF;
    for (int i = 0; i < 6; i++) begin
      a = rb[i]; we = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("rb%0d do_a", i), do_a, INIT);
      chk($sformatf("rb%0d vld_a", i), {31'b0, vld_a}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("rb%0d do_b", i), do_b, INIT);
      chk($sformatf("rb%0d vld_b", i), {31'b0, vld_b}, 32'd1);
    end

`ifdef RAMSPX_PAR_EN
    for (int k = 0; k < 2; k++) begin
      a = 11'h007; we = 1'b1; wm = ONES; di = 32'h0000_0001; pinj = (k == 0);
      @(posedge clk);
      #1;
      we = 1'b0; pinj = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("par%0d perr_a", k), {30'b0, perr_a, vld_a}, {30'b0, (k == 0), 1'b1});
      @(posedge clk);
      #1;
      chk($sformatf("par%0d perr_b", k), {30'b0, perr_b, vld_b}, {30'b0, (k == 0), 1'b1});
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
